// File: rtl/ram_arbiter.sv
// Three-way arbiter in front of a synchronous single-port RAM: loader (write-only,
// highest priority), CPU (read/write) and blitter (read-only, burst-fair with CPU).
module ram_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  input  logic        blt_req,
  input  logic [11:0] blt_addr,
  output logic        blt_ack,
  output logic        blt_rvalid,
  input  logic        ldr_req,
  input  logic [11:0] ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds x_req and its address/data stable until it sees
  // x_ack high in a cycle; that cycle is the transfer. Reads return x_rvalid two
  // cycles after the ack cycle with the data on the shared rdata bus.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_LDR = 2'd1,
    OWN_CPU = 2'd2,
    OWN_BLT = 2'd3
  } owner_t;

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  owner_t     state, state_nxt;
  logic [7:0] burst_cnt;
  logic       last_blt;   // 1 when the blitter was the most recently served of CPU/blitter
  logic       burst_full;
  logic       any_ack;
  logic       rd_cpu_q, rd_blt_q;

  assign burst_full = (burst_cnt >= MAX_B);
  assign any_ack    = cpu_ack | blt_ack | ldr_ack;
  assign dbg_state  = state;

  // State register
  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = IDLE;
    if (ldr_req) begin
      state_nxt = OWN_LDR;
    end else begin
      case (state)
        OWN_CPU: begin
          if (cpu_req && !(blt_req && burst_full)) state_nxt = OWN_CPU;
          else if (blt_req)                        state_nxt = OWN_BLT;
          else                                     state_nxt = IDLE;
        end
        OWN_BLT: begin
          if (blt_req && !(cpu_req && burst_full)) state_nxt = OWN_BLT;
          else if (cpu_req)                        state_nxt = OWN_CPU;
          else                                     state_nxt = IDLE;
        end
        default: begin
          if (cpu_req && blt_req) state_nxt = last_blt ? OWN_CPU : OWN_BLT;
          else if (cpu_req)       state_nxt = OWN_CPU;
          else if (blt_req)       state_nxt = OWN_BLT;
          else                    state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    cpu_ack = (state == OWN_CPU) && cpu_req;
    blt_ack = (state == OWN_BLT) && blt_req;
    ldr_ack = (state == OWN_LDR) && ldr_req;
  end

  // Burst length of the current owner, counting the cycle it is granted in
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      burst_cnt <= 8'd0;
      last_blt  <= 1'b1;
    end else begin
      if (state_nxt != state)
        burst_cnt <= (state_nxt == IDLE) ? 8'd0 : 8'd1;
      else if (any_ack && burst_cnt < MAX_B)
        burst_cnt <= burst_cnt + 8'd1;
      if (cpu_ack)      last_blt <= 1'b0;
      else if (blt_ack) last_blt <= 1'b1;
    end
  end

  // Memory command register: one accepted access becomes one mem_en cycle
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 12'd0;
      mem_wdata <= 8'd0;
    end else begin
      mem_en    <= any_ack;
      mem_wr    <= 1'b0;
      mem_addr  <= 12'd0;
      mem_wdata <= 8'd0;
      if (ldr_ack) begin
        mem_wr    <= 1'b1;
        mem_addr  <= ldr_addr;
        mem_wdata <= ldr_wdata;
      end else if (cpu_ack) begin
        mem_wr    <= cpu_wr;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wr ? cpu_wdata : 8'd0;
      end else if (blt_ack) begin
        mem_addr  <= blt_addr;
      end
    end
  end

  // Read-return tags follow the access through the RAM latency, independent of ownership
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rd_cpu_q   <= 1'b0;
      rd_blt_q   <= 1'b0;
      cpu_rvalid <= 1'b0;
      blt_rvalid <= 1'b0;
    end else begin
      rd_cpu_q   <= cpu_ack && !cpu_wr;
      rd_blt_q   <= blt_ack;
      cpu_rvalid <= rd_cpu_q;
      blt_rvalid <= rd_blt_q;
    end
  end

  assign rdata = (cpu_rvalid || blt_rvalid) ? mem_rdata : 8'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, cycle-level ownership model and scoreboard
// queues for memory commands and read returns.
module tb_ram_arbiter;

  localparam int MB = 4;
  localparam logic [1:0] O_IDLE = 2'd0, O_LDR = 2'd1, O_CPU = 2'd2, O_BLT = 2'd3;

  logic        clk = 1'b0;
  logic        res;
  logic        cpu_req, cpu_wr, cpu_ack, cpu_rvalid;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        blt_req, blt_ack, blt_rvalid;
  logic [11:0] blt_addr;
  logic        ldr_req, ldr_ack;
  logic [11:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic        mem_en, mem_wr;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata, rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  ram    [4096];
  logic [7:0]  shadow [4096];
  logic [20:0] mem_q[$];   // {wr, addr, wdata}
  logic [40:0] rd_q[$];    // {due cycle, is_blt, data}

  logic [1:0]  m_owner;
  int          m_run;
  logic        m_last_blt;
  logic [1:0]  m_nxt;

  ram_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .res(res),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .blt_req(blt_req), .blt_addr(blt_addr), .blt_ack(blt_ack), .blt_rvalid(blt_rvalid),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // RAM model: synchronous, one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Ownership model
  function automatic logic [1:0] model_next(input logic [1:0] own, input int run,
                                            input logic lastb, input logic c,
                                            input logic b, input logic l);
    logic lb;
    lb = lastb;
    if (own == O_CPU && c) lb = 1'b0;
    if (own == O_BLT && b) lb = 1'b1;
    if (l) return O_LDR;
    if (own == O_CPU && c && !(b && run >= MB)) return O_CPU;
    if (own == O_BLT && b && !(c && run >= MB)) return O_BLT;
    if (c && b) return lb ? O_CPU : O_BLT;
    if (c) return O_CPU;
    if (b) return O_BLT;
    return O_IDLE;
  endfunction

  assign m_nxt = model_next(m_owner, m_run, m_last_blt, cpu_req, blt_req, ldr_req);

  always @(posedge clk or posedge res) begin
    if (res) begin
      m_owner    <= O_IDLE;
      m_run      <= 0;
      m_last_blt <= 1'b1;
    end else begin
      m_owner <= m_nxt;
      if (m_nxt != m_owner)  m_run <= (m_nxt == O_IDLE) ? 0 : 1;
      else if (m_run < MB)   m_run <= m_run + 1;
      if (m_owner == O_CPU && cpu_req)      m_last_blt <= 1'b0;
      else if (m_owner == O_BLT && blt_req) m_last_blt <= 1'b1;
    end
  end

  // Scoreboard: pop/compare what is due this cycle, then push what this cycle accepts
  always @(negedge clk) begin
    logic e_cpu, e_blt, e_ldr;
    logic [20:0] em;
    logic [40:0] er;
    if (res) begin
      mem_q.delete();
      rd_q.delete();
    end else begin
      if (mem_q.size() > 0) begin
        em = mem_q.pop_front();
        check("mem_en", 32'(mem_en), 32'd1);
        check("mem_cmd", 32'({mem_wr, mem_addr, mem_wdata}), 32'(em));
      end else begin
        check("mem_en_idle", 32'(mem_en), 32'd0);
      end
      if (rd_q.size() > 0 && rd_q[0][40:9] == 32'(cyc)) begin
        er = rd_q.pop_front();
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(!er[8]));
        check("blt_rvalid", 32'(blt_rvalid), 32'(er[8]));
        check("rdata", 32'(rdata), 32'(er[7:0]));
      end else begin
        check("rvalid_idle", 32'({cpu_rvalid, blt_rvalid}), 32'd0);
      end
      e_cpu = (m_owner == O_CPU) && cpu_req;
      e_blt = (m_owner == O_BLT) && blt_req;
      e_ldr = (m_owner == O_LDR) && ldr_req;
      check("state", 32'(dbg_state), 32'(m_owner));
      check("acks", 32'({cpu_ack, blt_ack, ldr_ack}), 32'({e_cpu, e_blt, e_ldr}));
      if (e_ldr) begin
        mem_q.push_back({1'b1, ldr_addr, ldr_wdata});
        shadow[ldr_addr] = ldr_wdata;
      end
      if (e_cpu) begin
        mem_q.push_back({cpu_wr, cpu_addr, cpu_wr ? cpu_wdata : 8'd0});
        if (cpu_wr) shadow[cpu_addr] = cpu_wdata;
        else        rd_q.push_back({32'(cyc + 2), 1'b0, shadow[cpu_addr]});
      end
      if (e_blt) begin
        mem_q.push_back({1'b0, blt_addr, 8'd0});
        rd_q.push_back({32'(cyc + 2), 1'b1, shadow[blt_addr]});
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic wr, input logic [11:0] addr, input logic [7:0] data);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = data;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1'b1;
    end
    check("cpu_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({cpu_ack, blt_ack, ldr_ack, cpu_rvalid, blt_rvalid, mem_en, mem_wr,
                    mem_addr, mem_wdata, dbg_state}), 32'd0);
  endtask

  initial begin
    #200000;
    check("global_timeout", 32'd0, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n, last, blt_after;
    logic got;
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = 8'(i) ^ 8'(i >> 4);
      shadow[i] = ram[i];
    end
    ram[12'h200] = 8'hA5;
    shadow[12'h200] = 8'hA5;
    res = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    blt_req = 0; blt_addr = 0; ldr_req = 0; ldr_addr = 0; ldr_wdata = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    #2 res = 1'b0;

    // Both requesters held from reset: CPU first, then alternating bursts of MB
    @(posedge clk); #1;
    cpu_req = 1'b1; blt_req = 1'b1;
    n = 0; last = 0;
    for (int i = 0; i < 40 && n < 12; i++) begin
      @(negedge clk);
      if (cpu_ack || blt_ack) begin
        check("burst_owner_is_blt", 32'(blt_ack), 32'((n / MB) % 2));
        if (n > 0) check("burst_gap", 32'(cyc - last), 32'd1);
        last = cyc;
        n++;
      end
      @(posedge clk); #1;
      cpu_addr = 12'($urandom_range(0, 4095));
      blt_addr = 12'($urandom_range(0, 4095));
    end
    check("burst_acks", 32'(n), 32'd12);
    cpu_req = 1'b0; blt_req = 1'b0;
    idle(4);

    // CPU read of a known word, CPU write then read-back
    cpu_access(1'b0, 12'h200, 8'h00);
    idle(3);
    cpu_access(1'b1, 12'h300, 8'h7F);
    idle(3);
    cpu_access(1'b0, 12'h300, 8'h00);
    idle(3);

    // Loader preempts a blitter burst
    blt_req = 1'b1;
    repeat (6) begin
      blt_addr = 12'($urandom_range(0, 4095));
      idle(1);
    end
    ldr_req = 1'b1; ldr_addr = 12'h050; ldr_wdata = 8'h3C;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (ldr_ack) got = 1'b1;
    end
    check("ldr_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    ldr_req = 1'b0;
    blt_after = 0;
    repeat (4) begin
      @(negedge clk);
      if (blt_ack) blt_after++;
      @(posedge clk); #1;
      blt_addr = 12'($urandom_range(0, 4095));
    end
    check("blt_resumed", 32'(blt_after > 0), 32'd1);
    blt_req = 1'b0;
    idle(3);
    cpu_access(1'b0, 12'h050, 8'h00);
    idle(3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_wr    = 1'($urandom_range(0, 1));
      cpu_addr  = 12'($urandom_range(0, 4095));
      cpu_wdata = 8'($urandom_range(0, 255));
      blt_req   = ($urandom_range(0, 3) != 0);
      blt_addr  = 12'($urandom_range(0, 4095));
      ldr_req   = ($urandom_range(0, 7) == 0);
      ldr_addr  = 12'($urandom_range(0, 4095));
      ldr_wdata = 8'($urandom_range(0, 255));
      idle(1);
    end
    cpu_req = 1'b0; blt_req = 1'b0; ldr_req = 1'b0;
    idle(5);

    // Reset between a blitter ack and its read return
    blt_req = 1'b1; blt_addr = 12'h123;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (blt_ack) got = 1'b1;
    end
    check("blt_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    blt_req = 1'b0;
    #2 res = 1'b1;
    #1 check_all_zero("async_reset_outputs");
    @(negedge clk);
    @(posedge clk); #3;
    res = 1'b0;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
